dmem_mmio_responder: RTL and testbench
======================================

DMEM_MMIO_RESPONDER -- requirements
Module: dmem_mmio_responder

Interface
REQ-001 Parameter BASE, default 32'hFFFF_0000, is the base address of the 256-byte MMIO window; the window is selected when addr[31:8] == BASE[31:8].
REQ-002 Parameter FIFO_DEPTH, default 8, is the number of TX byte FIFO entries; it SHALL be a power of 2, minimum 2.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 addr  in  32  byte address from the core's data-memory port.
REQ-006 we  in  4  byte write enables; bit i enables wdata[8i+7:8i].
REQ-007 re  in  1  read request (MemRead).
REQ-008 wdata  in  32  store data, already lane-aligned.
REQ-009 rdata  out  32  registered read data, valid one cycle after the request.
REQ-010 tx_data  out  8  byte at the FIFO head.
REQ-011 tx_valid  out  1  FIFO non-empty.
REQ-012 tx_ready  in  1  sink accepts tx_data this cycle.
REQ-013 timer_irq  out  1  timer interrupt level.

Function
REQ-014 Register map (offset from BASE): 0x00 TXDATA (WO); 0x04 STATUS; 0x08 MTIME_LO; 0x0C MTIME_HI; 0x10 MTIMECMP_LO; 0x14 MTIMECMP_HI; 0x18 SCRATCH. Decode uses addr[7:2]; addr[1:0] are ignored.
REQ-015 Unmapped offsets and out-of-window addresses: writes ignored; reads return 0.
REQ-016 Read latency is exactly 1 cycle: rdata <= (re && window hit) ? register value : 0. rdata holds 0 on any cycle following no read.
REQ-017 STATUS read value is {.., count[11:4], 1'b0, overflow[2], empty[1], full[0]}; all other bits read 0; count is zero-extended to 8 bits.
REQ-018 A write to TXDATA with we[0]=1 pushes wdata[7:0]. If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and overflow is set (sticky).
REQ-019 A pop occurs when tx_valid && tx_ready; head advances and count decrements.
REQ-020 Simultaneous push and pop: the push is accepted even when full; count is unchanged. When empty, a push with tx_ready=1 is not bypassed; tx_valid rises the next cycle.
REQ-021 A write to STATUS with we[0]=1 and wdata[2]=1 clears overflow. If an overflowing push occurs in the same cycle, the set wins.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH. Full is count==FIFO_DEPTH; empty is count==0.
REQ-023 mtime is a 64-bit counter that increments every cycle and wraps from 2^64-1 to 0. MTIME_LO/HI are read-only; writes are ignored.
REQ-024 A read of MTIME_LO returns mtime[31:0] and, in the same cycle, latches mtime[63:32] into a shadow register. A read of MTIME_HI returns the shadow.
REQ-025 MTIMECMP_LO/HI and SCRATCH are writable per byte lane under we.
REQ-026 timer_irq SHALL be registered: timer_irq <= (mtime >= mtimecmp), unsigned 64-bit compare.
REQ-027 Concurrent re and we to the same register: rdata returns the pre-write value.

Reset
REQ-028 Whenever rst_n=0 at a rising edge, the following SHALL take these values: rdata=0, FIFO pointers and count=0 (tx_valid=0), overflow=0, mtime=0, shadow=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, SCRATCH=0, timer_irq=0.
REQ-029 Reset asserted mid-transfer discards all FIFO contents. tx_data is don't-care while tx_valid=0.

Verification
REQ-030 Write SCRATCH with we=4'b0101, wdata=0xAABBCCDD after reset, then read SCRATCH -> rdata=0x00BB00DD exactly 1 cycle after re.
REQ-031 Hold tx_ready=0 and push 9 bytes 0x01..0x09 -> STATUS reads full=1, count=8, overflow=1. Then set tx_ready=1 -> sink receives 0x01..0x08 in order, and tx_valid=0 afterwards.
REQ-032 Fill the FIFO to full, then push 0x55 in the same cycle as a pop -> count stays 8, overflow stays 0, and 0x55 is the last byte out.
REQ-033 Write mtimecmp=20 (HI=0) at cycle 5 -> timer_irq=0 until the edge after mtime reaches 20, then 1. Then write MTIMECMP_HI=0xFFFFFFFF -> timer_irq=0 on the cycle after next.
REQ-034 Force mtime=0x0000_0000_FFFF_FFFF (bench backdoor) and read LO, then HI 3 cycles later -> LO=0xFFFFFFFF and HI=0 (shadow); a later LO/HI pair gives HI=1.
REQ-035 Issue a read to BASE+0x1C and to 0x0000_0100, and a write to 0x0000_0100 -> rdata=0 for the reads, and no state changes.

Source files
------------

// File: rtl/dmem_mmio_responder.sv
// MMIO responder on the core's data-memory port: TX byte FIFO, 64-bit machine timer
// with compare interrupt and a scratch register, all inside one 256-byte window.
module dmem_mmio_responder #(
    parameter logic [31:0] BASE       = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [3:0]  we,
    input  logic        re,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        timer_irq
);
    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C     = (AW + 1)'(FIFO_DEPTH);
    localparam logic [5:0]  OFF_TXDATA  = 6'h00;
    localparam logic [5:0]  OFF_STATUS  = 6'h01;
    localparam logic [5:0]  OFF_MT_LO   = 6'h02;
    localparam logic [5:0]  OFF_MT_HI   = 6'h03;
    localparam logic [5:0]  OFF_CMP_LO  = 6'h04;
    localparam logic [5:0]  OFF_CMP_HI  = 6'h05;
    localparam logic [5:0]  OFF_SCRATCH = 6'h06;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [63:0]   mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic [31:0]   shadow_q, shadow_d, scratch_q, scratch_d, rdata_q, rdata_d;
    logic          timer_irq_q, timer_irq_d;

    logic          hit_s, fifo_full_s, fifo_empty_s;
    logic          push_req_s, pop_s, push_ok_s, ovf_set_s, ovf_clr_s;
    logic [5:0]    off_s;
    logic [31:0]   status_s, rd_val_s;
    logic          unused_addr_s;

    assign hit_s         = (addr[31:8] == BASE[31:8]);
    assign off_s         = addr[7:2];
    assign unused_addr_s = ^addr[1:0];

    assign fifo_empty_s = (count_q == {(AW + 1){1'b0}});
    assign fifo_full_s  = (count_q == DEPTH_C);
    assign pop_s        = !fifo_empty_s && tx_ready;
    assign push_req_s   = hit_s && (off_s == OFF_TXDATA) && we[0];
    // A full FIFO still takes the push when a pop frees the head slot in the same cycle.
    assign push_ok_s    = push_req_s && (!fifo_full_s || pop_s);
    assign ovf_set_s    = push_req_s && fifo_full_s && !pop_s;
    assign ovf_clr_s    = hit_s && (off_s == OFF_STATUS) && we[0] && wdata[2];
    assign status_s     = {20'h0_0000, 8'(count_q), 1'b0, overflow_q, fifo_empty_s, fifo_full_s};

    // Read mux and registered read data; reads see pre-write register values.
    always_comb begin
        rd_val_s = 32'h0000_0000;
        case (off_s)
            OFF_STATUS:  rd_val_s = status_s;
            OFF_MT_LO:   rd_val_s = mtime_q[31:0];
            OFF_MT_HI:   rd_val_s = shadow_q;
            OFF_CMP_LO:  rd_val_s = mtimecmp_q[31:0];
            OFF_CMP_HI:  rd_val_s = mtimecmp_q[63:32];
            OFF_SCRATCH: rd_val_s = scratch_q;
            default:     rd_val_s = 32'h0000_0000;
        endcase
        if (re && hit_s) begin
            rdata_d = rd_val_s;
        end else begin
            rdata_d = 32'h0000_0000;
        end
        if (re && hit_s && (off_s == OFF_MT_LO)) begin
            shadow_d = mtime_q[63:32];
        end else begin
            shadow_d = shadow_q;
        end
    end

    // FIFO pointer, occupancy and overflow next state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
        if (ovf_set_s) begin
            overflow_d = 1'b1;
        end else if (ovf_clr_s) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Timer, compare and scratch next state.
    always_comb begin
        mtime_d     = mtime_q + 64'd1;
        mtimecmp_d  = mtimecmp_q;
        scratch_d   = scratch_q;
        timer_irq_d = (mtime_q >= mtimecmp_q);
        if (hit_s && (off_s == OFF_CMP_LO)) begin
            mtimecmp_d = {mtimecmp_q[63:32], lane_merge(mtimecmp_q[31:0], wdata, we)};
        end else if (hit_s && (off_s == OFF_CMP_HI)) begin
            mtimecmp_d = {lane_merge(mtimecmp_q[63:32], wdata, we), mtimecmp_q[31:0]};
        end else begin
            mtimecmp_d = mtimecmp_q;
        end
        if (hit_s && (off_s == OFF_SCRATCH)) begin
            scratch_d = lane_merge(scratch_q, wdata, we);
        end else begin
            scratch_d = scratch_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {(AW + 1){1'b0}};
            overflow_q  <= 1'b0;
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            shadow_q    <= 32'h0000_0000;
            scratch_q   <= 32'h0000_0000;
            rdata_q     <= 32'h0000_0000;
            timer_irq_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            shadow_q    <= shadow_d;
            scratch_q   <= scratch_d;
            rdata_q     <= rdata_d;
            timer_irq_q <= timer_irq_d;
        end
    end

    // FIFO storage; contents are meaningless while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata[7:0];
        end
    end

    assign rdata     = rdata_q;
    assign tx_data   = mem_q[rd_ptr_q];
    assign tx_valid  = !fifo_empty_s;
    assign timer_irq = timer_irq_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: register table plus FIFO, timer and reset sequences.
module tb_dmem_mmio_responder;
    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam int NV = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [3:0]  we;
    logic        re;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        timer_irq;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] m = 64'd0;
    logic [63:0] m_pre;
    logic [7:0]  got[$];

    typedef struct {
        logic [31:0] a;
        logic [3:0]  w;
        logic        r;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[NV];

    dmem_mmio_responder #(.BASE(BASE), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .re(re), .wdata(wdata),
        .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // m mirrors the expected mtime value after each edge
    task automatic tick();
        logic rs;
        rs = rst_n;
        @(posedge clk);
        if (!rs) m = 64'd0;
        else m = m + 64'd1;
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus(input logic [31:0] a, input logic [3:0] w, input logic r, input logic [31:0] d);
        addr = a; we = w; re = r; wdata = d;
        tick();
        addr = 32'h0; we = 4'h0; re = 1'b0; wdata = 32'h0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
        bus(a, 4'h0, 1'b1, 32'h0);
        check(name, rdata, exp);
    endtask

    task automatic drain();
        got.delete();
        tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!tx_valid) break;
            got.push_back(tx_data);
            tick();
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{BASE + 32'h18, 4'b0101, 1'b0, 32'hAABB_CCDD, 32'h0000_0000};
        vecs[1]  = '{BASE + 32'h18, 4'b0000, 1'b1, 32'h0000_0000, 32'h00BB_00DD};
        vecs[2]  = '{BASE + 32'h18, 4'b1010, 1'b1, 32'h1122_3344, 32'h00BB_00DD};
        vecs[3]  = '{BASE + 32'h18, 4'b0000, 1'b1, 32'h0000_0000, 32'h11BB_33DD};
        vecs[4]  = '{BASE + 32'h1C, 4'b0000, 1'b1, 32'h0000_0000, 32'h0000_0000};
        vecs[5]  = '{32'h0000_0100, 4'b0000, 1'b1, 32'h0000_0000, 32'h0000_0000};
        vecs[6]  = '{32'h0000_0100, 4'b1111, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[7]  = '{BASE + 32'h1C, 4'b1111, 1'b0, 32'h1234_5678, 32'h0000_0000};
        vecs[8]  = '{32'h0000_0118, 4'b1111, 1'b0, 32'h0000_0000, 32'h0000_0000};
        vecs[9]  = '{BASE + 32'h1B, 4'b0000, 1'b1, 32'h0000_0000, 32'h11BB_33DD};
        vecs[10] = '{BASE + 32'h04, 4'b0000, 1'b1, 32'h0000_0000, 32'h0000_0002};
        vecs[11] = '{BASE + 32'h10, 4'b0011, 1'b0, 32'h0000_ABCD, 32'h0000_0000};
        vecs[12] = '{BASE + 32'h10, 4'b0000, 1'b1, 32'h0000_0000, 32'hFFFF_ABCD};
        vecs[13] = '{BASE + 32'h14, 4'b0000, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[14] = '{BASE + 32'h10, 4'b1111, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[15] = '{BASE + 32'h00, 4'b0000, 1'b1, 32'h0000_0000, 32'h0000_0000};

        addr = 32'h0; we = 4'h0; re = 1'b0; wdata = 32'h0; tx_ready = 1'b0; rst_n = 1'b0;
        tick(); tick();
        check("rst_rdata", rdata, 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_irq", 32'(timer_irq), 32'h0);
        rst_n = 1'b1;
        rd_chk(BASE + 32'h08, 32'h0000_0000, "rst_mtime_lo");
        rd_chk(BASE + 32'h04, 32'h0000_0002, "rst_status");
        rd_chk(BASE + 32'h18, 32'h0000_0000, "rst_scratch");

        for (int i = 0; i < NV; i++) begin
            bus(vecs[i].a, vecs[i].w, vecs[i].r, vecs[i].d);
            check($sformatf("vec%0d", i), rdata, vecs[i].exp);
        end

        // nine pushes into an 8-deep FIFO with the sink stalled
        for (int i = 1; i <= 9; i++) bus(BASE, 4'b0001, 1'b0, 32'(i));
        check("ovf_tx_valid", 32'(tx_valid), 32'h1);
        check("ovf_tx_head", 32'(tx_data), 32'h01);
        rd_chk(BASE + 32'h04, 32'h0000_0085, "ovf_status");
        drain();
        check("ovf_drain_cnt", 32'(got.size()), 32'd8);
        for (int i = 0; i < got.size() && i < 8; i++)
            check($sformatf("ovf_byte%0d", i), 32'(got[i]), 32'(i + 1));
        check("ovf_drained_valid", 32'(tx_valid), 32'h0);
        rd_chk(BASE + 32'h04, 32'h0000_0006, "ovf_sticky");
        bus(BASE + 32'h04, 4'b0001, 1'b0, 32'h0000_0004);
        rd_chk(BASE + 32'h04, 32'h0000_0002, "ovf_cleared");

        // push into an empty FIFO with the sink ready must not bypass
        tx_ready = 1'b1;
        bus(BASE, 4'b0001, 1'b0, 32'h77);
        check("nobypass_valid", 32'(tx_valid), 32'h1);
        check("nobypass_data", 32'(tx_data), 32'h77);
        tick();
        check("nobypass_popped", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // fill, then push 0x55 together with a pop
        for (int i = 0; i < 8; i++) bus(BASE, 4'b0001, 1'b0, 32'hA0 + 32'(i));
        rd_chk(BASE + 32'h04, 32'h0000_0081, "fill_status");
        tx_ready = 1'b1;
        bus(BASE, 4'b0001, 1'b0, 32'h55);
        tx_ready = 1'b0;
        rd_chk(BASE + 32'h04, 32'h0000_0081, "pushpop_status");
        drain();
        check("pushpop_cnt", 32'(got.size()), 32'd8);
        for (int i = 0; i < got.size() && i < 8; i++)
            check($sformatf("pushpop_byte%0d", i), 32'(got[i]), (i < 7) ? 32'hA1 + 32'(i) : 32'h55);

        // reset in the middle of a transfer
        bus(BASE, 4'b0001, 1'b0, 32'h11);
        bus(BASE, 4'b0001, 1'b0, 32'h22);
        bus(BASE + 32'h18, 4'b1111, 1'b0, 32'hDEAD_BEEF);
        bus(BASE + 32'h10, 4'b1111, 1'b0, 32'h0000_1234);
        rd_chk(BASE + 32'h18, 32'hDEAD_BEEF, "pre_rst_scratch");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid", 32'(tx_valid), 32'h0);
        check("mid_rst_rdata", rdata, 32'h0);
        rd_chk(BASE + 32'h04, 32'h0000_0002, "mid_rst_status");
        rd_chk(BASE + 32'h18, 32'h0000_0000, "mid_rst_scratch");
        rd_chk(BASE + 32'h10, 32'hFFFF_FFFF, "mid_rst_cmp_lo");

        // timer compare at 20
        bus(BASE + 32'h14, 4'b1111, 1'b0, 32'h0);
        bus(BASE + 32'h10, 4'b1111, 1'b0, 32'd20);
        for (int i = 0; i < 30; i++) begin
            m_pre = m;
            tick();
            check($sformatf("irq_m%0d", m_pre), 32'(timer_irq), 32'(m_pre >= 64'd20));
        end
        bus(BASE + 32'h08, 4'b1111, 1'b0, 32'h0);
        rd_chk(BASE + 32'h08, m[31:0], "mtime_lo_model");
        bus(BASE + 32'h14, 4'b1111, 1'b0, 32'hFFFF_FFFF);
        check("irq_still_set", 32'(timer_irq), 32'h1);
        tick();
        check("irq_cleared", 32'(timer_irq), 32'h0);

        // mtime LO/HI shadow across a carry
        force dut.mtime_q = 64'h0000_0000_FFFF_FFFF;
        rd_chk(BASE + 32'h08, 32'hFFFF_FFFF, "force_lo");
        release dut.mtime_q;
        tick(); tick();
        rd_chk(BASE + 32'h0C, 32'h0000_0000, "shadow_hi0");
        bus(BASE + 32'h08, 4'h0, 1'b1, 32'h0);
        rd_chk(BASE + 32'h0C, 32'h0000_0001, "shadow_hi1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
